// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO through a valid/ready handshake.
// Frames are LSB-first with configurable data width, optional parity and 1 or 2 stop bits.
module uart_tx_fifo #(
  parameter int CLK_DIV    = 868,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_BITS-1:0]          in_data,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_MAX   = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t                 state;
  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_bit;
  logic [CW-1:0]          bit_cnt;
  logic [IW-1:0]          idx;
  logic                   stop_idx;
  logic                   push, pop, last_bit, frame_end;
  logic [DATA_BITS-1:0]   head;

  function automatic logic par_of(input logic [DATA_BITS-1:0] w);
    return (PARITY == 1) ? ~^w : ^w;
  endfunction

  assign in_ready  = !rst && (fifo_level < LW'(FIFO_DEPTH));
  assign push      = in_valid && in_ready;
  assign last_bit  = (bit_cnt == CNT_MAX);
  assign frame_end = (state == STOP) && last_bit && (stop_idx == STOP_LAST);
  // Pop either to start from idle or to chain straight into the next frame.
  assign pop       = (fifo_level != '0) && ((state == IDLE) || frame_end);
  assign head      = mem[rd_ptr];
  assign busy      = (state != IDLE) || (fifo_level != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      shreg    <= '0;
      par_bit  <= 1'b0;
      bit_cnt  <= '0;
      idx      <= '0;
      stop_idx <= 1'b0;
    end else begin
      if (state != IDLE) bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shreg   <= head;
            par_bit <= par_of(head);
            tx      <= 1'b0;
            bit_cnt <= '0;
            state   <= START;
          end
        end
        START: if (last_bit) begin
          tx    <= shreg[0];
          idx   <= '0;
          state <= DATA;
        end
        DATA: if (last_bit) begin
          if (idx == IDX_LAST) begin
            if (PARITY != 0) begin
              tx    <= par_bit;
              state <= PAR;
            end else begin
              tx       <= 1'b1;
              stop_idx <= 1'b0;
              state    <= STOP;
            end
          end else begin
            shreg <= shreg >> 1;
            tx    <= shreg[1];
            idx   <= idx + 1'b1;
          end
        end
        PAR: if (last_bit) begin
          tx       <= 1'b1;
          stop_idx <= 1'b0;
          state    <= STOP;
        end
        STOP: if (last_bit) begin
          if (stop_idx == STOP_LAST) begin
            if (pop) begin
              shreg   <= head;
              par_bit <= par_of(head);
              tx      <= 1'b0;
              state   <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            stop_idx <= stop_idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
